// File: rtl/itag_array_if.sv
// itag_array_if: request/fill/flush bus between the I-cache controller and
// the instruction tag array.
//   master : cache controller side (drives req_*, fill_*, flush)
//   slave  : tag array side (drives rsp_*, fill_way, busy)
// Ports carried:
//   req_valid/req_index/req_tag/req_part     lookup request
//   fill_valid/fill_index/fill_tag/fill_part tag install
//   flush                                    whole-array invalidate pulse
//   fill_way, busy, rsp_valid, rsp_hit, rsp_way  results and status
`ifndef I_TAG_WIDTH
`define I_TAG_WIDTH 8
`endif
`ifndef I_INDEX_WIDTH
`define I_INDEX_WIDTH 4
`endif

interface itag_array_if #(
  parameter int TAG_W = `I_TAG_WIDTH,
  parameter int IDX_W = `I_INDEX_WIDTH,
  parameter int WAY_W = 2
);
  logic             req_valid;
  logic [IDX_W-1:0] req_index;
  logic [TAG_W-1:0] req_tag;
  logic             req_part;
  logic             fill_valid;
  logic [IDX_W-1:0] fill_index;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_part;
  logic [WAY_W-1:0] fill_way;
  logic             flush;
  logic             busy;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [WAY_W-1:0] rsp_way;

  modport master (
    output req_valid, req_index, req_tag, req_part,
    output fill_valid, fill_index, fill_tag, fill_part, flush,
    input  fill_way, busy, rsp_valid, rsp_hit, rsp_way
  );

  modport slave (
    input  req_valid, req_index, req_tag, req_part,
    input  fill_valid, fill_index, fill_tag, fill_part, flush,
    output fill_way, busy, rsp_valid, rsp_hit, rsp_way
  );
endinterface

// File: rtl/itag_array.sv
// itag_array: WAYS-way set-associative instruction tag store.
// Ways are split into a low partition (0..LOW_WAYS-1) and a high partition
// (LOW_WAYS..WAYS-1). Lookups return hit/way one cycle after the request,
// fills pick the lowest invalid way of the partition or, when the partition
// is full, that set's round-robin pointer. A flush engine clears one set per
// cycle; reset also starts a sweep.
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous active-high reset
//   bus  itag_array_if slave: req_*, fill_*, flush in; rsp_*, fill_way, busy out
`ifndef I_TAG_WIDTH
`define I_TAG_WIDTH 8
`endif
`ifndef I_INDEX_WIDTH
`define I_INDEX_WIDTH 4
`endif

module itag_array #(
  parameter int WAYS     = 4,
  parameter int LOW_WAYS = 2,
  parameter int TAG_W    = `I_TAG_WIDTH,
  parameter int IDX_W    = `I_INDEX_WIDTH,
  parameter int WAY_W    = $clog2(WAYS)
) (
  input logic         clk,
  input logic         rst,
  itag_array_if.slave bus
);
  localparam int SETS = 1 << IDX_W;
  localparam logic [WAYS-1:0] LOW_MASK = WAYS'((1 << LOW_WAYS) - 1);

  typedef enum logic {ST_SWEEP = 1'b0, ST_IDLE = 1'b1} state_e;

  state_e           state_r, state_nxt_s;
  logic [IDX_W-1:0] cnt_r, cnt_nxt_s;
  logic             sweep_clr_s, req_acc_s, fill_acc_s;

  logic [WAYS-1:0]  valid_r  [SETS];
  logic [TAG_W-1:0] tag_r    [SETS][WAYS];
  // Pointers hold absolute way numbers inside their own partition.
  logic [WAY_W-1:0] ptr_lo_r [SETS];
  logic [WAY_W-1:0] ptr_hi_r [SETS];

  logic [WAYS-1:0]  req_mask_s, tag_eq_s, match_s;
  logic             lk_hit_s;
  logic [WAY_W-1:0] lk_way_s;

  logic [WAYS-1:0]  fill_mask_s, free_s;
  logic [WAY_W-1:0] ptr_cur_s, ptr_adv_s, ptr_last_s, ptr_base_s, victim_s;
  logic             use_ptr_s;

  logic             rsp_valid_r, rsp_hit_r;
  logic [WAY_W-1:0] rsp_way_r, fill_way_r;

  // State and sweep counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_SWEEP;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; flush has priority over req/fill and restarts the sweep.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    sweep_clr_s = 1'b0;
    req_acc_s   = 1'b0;
    fill_acc_s  = 1'b0;
    case (state_r)
      ST_SWEEP: begin
        sweep_clr_s = 1'b1;
        if (bus.flush) begin
          cnt_nxt_s   = '0;
          state_nxt_s = ST_SWEEP;
        end else begin
          cnt_nxt_s = cnt_r + IDX_W'(1);
          if (cnt_r == {IDX_W{1'b1}}) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_SWEEP;
          end
        end
      end
      ST_IDLE: begin
        if (bus.flush) begin
          state_nxt_s = ST_SWEEP;
          cnt_nxt_s   = '0;
        end else begin
          req_acc_s  = bus.req_valid;
          fill_acc_s = bus.fill_valid;
        end
      end
      default: begin
        state_nxt_s = ST_SWEEP;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Lookup compare on current contents (read-before-write against a fill).
  always_comb begin
    tag_eq_s   = '0;
    req_mask_s = bus.req_part ? ~LOW_MASK : LOW_MASK;
    for (int w = 0; w < WAYS; w++) begin
      tag_eq_s[w] = (tag_r[bus.req_index][w] == bus.req_tag);
    end
    match_s  = req_mask_s & valid_r[bus.req_index] & tag_eq_s;
    lk_hit_s = |match_s;
    lk_way_s = '0;
    // Descending scan so the lowest matching way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      lk_way_s = match_s[w] ? WAY_W'(w) : lk_way_s;
    end
  end

  // Victim choice: lowest invalid way in the partition, else round-robin pointer.
  always_comb begin
    fill_mask_s = bus.fill_part ? ~LOW_MASK : LOW_MASK;
    free_s      = fill_mask_s & ~valid_r[bus.fill_index];
    ptr_cur_s   = bus.fill_part ? ptr_hi_r[bus.fill_index] : ptr_lo_r[bus.fill_index];
    ptr_last_s  = bus.fill_part ? WAY_W'(WAYS - 1) : WAY_W'(LOW_WAYS - 1);
    ptr_base_s  = bus.fill_part ? WAY_W'(LOW_WAYS) : WAY_W'(0);
    ptr_adv_s   = (ptr_cur_s == ptr_last_s) ? ptr_base_s : ptr_cur_s + WAY_W'(1);
    use_ptr_s   = ~|free_s;
    victim_s    = ptr_cur_s;
    for (int w = WAYS - 1; w >= 0; w--) begin
      victim_s = free_s[w] ? WAY_W'(w) : victim_s;
    end
  end

  // Valid bits and pointers: sweep clears one set, fills mark the victim valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        ptr_lo_r[s] <= WAY_W'(0);
        ptr_hi_r[s] <= WAY_W'(LOW_WAYS);
      end
    end else if (sweep_clr_s) begin
      valid_r[cnt_r]  <= '0;
      ptr_lo_r[cnt_r] <= WAY_W'(0);
      ptr_hi_r[cnt_r] <= WAY_W'(LOW_WAYS);
    end else if (fill_acc_s) begin
      valid_r[bus.fill_index][victim_s] <= 1'b1;
      if (use_ptr_s && bus.fill_part) begin
        ptr_hi_r[bus.fill_index] <= ptr_adv_s;
      end else if (use_ptr_s) begin
        ptr_lo_r[bus.fill_index] <= ptr_adv_s;
      end
    end
  end

  // Tag storage; contents survive reset, only valid bits gate them.
  always_ff @(posedge clk) begin
    if (!rst && fill_acc_s) begin
      tag_r[bus.fill_index][victim_s] <= bus.fill_tag;
    end
  end

  // Registered lookup response and reported fill way.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_hit_r   <= 1'b0;
      rsp_way_r   <= '0;
      fill_way_r  <= '0;
    end else begin
      rsp_valid_r <= req_acc_s;
      rsp_hit_r   <= req_acc_s & lk_hit_s;
      rsp_way_r   <= req_acc_s ? lk_way_s : WAY_W'(0);
      if (fill_acc_s) begin
        fill_way_r <= victim_s;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_hit   = rsp_hit_r;
  assign bus.rsp_way   = rsp_way_r;
  assign bus.fill_way  = fill_way_r;
  // Busy is masked while rst is held so every output reads 0 during reset.
  assign bus.busy      = (state_r == ST_SWEEP) & ~rst;
endmodule
